// File: rtl/ras_return_checker.sv
// Execute-side return-prediction checker. It tracks in-flight RAS predictions in
// order, confirms or refutes each one when EX resolves a `jr $ra`, and counts hits and misses.
module ras_return_checker #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     pred_valid,
  input  logic [31:0]              pred_target,
  input  logic                     pred_hit,
  output logic                     pred_ready,
  input  logic                     res_valid,
  input  logic [31:0]              res_target,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_COUNT = OCC_W'(DEPTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;

  logic [31:0]      tgt_q      [DEPTH];
  logic             hit_flag_q [DEPTH];

  logic enq, enq_ok, res_hit;

  assign pred_ready = (count_q != FULL_COUNT);
  assign enq        = pred_valid && pred_ready;
  // An empty queue has no prediction to confirm, so it can never produce a hit.
  assign res_hit    = (count_q != '0) && hit_flag_q[head_q] && (tgt_q[head_q] == res_target);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    hit_cnt_d        = hit_cnt_q;
    miss_cnt_d       = miss_cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    enq_ok           = 1'b0;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (res_valid && !res_hit) begin
      // Mispredict: everything younger is wrong-path, including a same-cycle enqueue.
      head_d           = '0;
      tail_d           = '0;
      count_d          = '0;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = res_target;
      miss_cnt_d       = (miss_cnt_q != '1) ? miss_cnt_q + 1'b1 : miss_cnt_q;
    end else begin
      if (res_valid) begin
        head_d    = head_q + 1'b1;
        hit_cnt_d = (hit_cnt_q != '1) ? hit_cnt_q + 1'b1 : hit_cnt_q;
      end
      if (enq) begin
        tail_d = tail_q + 1'b1;
        enq_ok = 1'b1;
      end
      count_d = count_q + OCC_W'(enq) - OCC_W'(res_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      hit_cnt_q        <= '0;
      miss_cnt_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      hit_cnt_q        <= hit_cnt_d;
      miss_cnt_q       <= miss_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // NOTE: entry storage has no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      tgt_q[tail_q]      <= pred_target;
      hit_flag_q[tail_q] <= pred_hit;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign hit_cnt        = hit_cnt_q;
  assign miss_cnt       = miss_cnt_q;
  assign q_count        = count_q;

endmodule

// File: tb/tb_ras_return_checker.sv
// Bench for ras_return_checker: redirects are scoreboarded by the cycle they must
// appear in; occupancy and counters are checked inline by each scenario task.
module tb_ras_return_checker;

  logic        clk = 1'b0;
  logic        reset, flush, pred_valid, pred_hit, res_valid;
  logic [31:0] pred_target, res_target;
  logic        pred_ready, redirect_valid;
  logic [31:0] redirect_pc, hit_cnt, miss_cnt;
  logic [3:0]  q_count;

  // Small instance used only for counter saturation.
  logic        s_res_valid;
  logic [31:0] s_res_target;
  logic        s_pred_valid = 1'b0, s_pred_hit = 1'b0, s_flush = 1'b0;
  logic [31:0] s_pred_target = '0;
  logic        s_pred_ready, s_redirect_valid;
  logic [31:0] s_redirect_pc;
  logic [1:0]  s_hit_cnt, s_miss_cnt, s_q_count;

  always #5 clk = ~clk;

  ras_return_checker dut (
    .clk(clk), .reset(reset), .flush(flush),
    .pred_valid(pred_valid), .pred_target(pred_target), .pred_hit(pred_hit),
    .pred_ready(pred_ready), .res_valid(res_valid), .res_target(res_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .q_count(q_count)
  );

  ras_return_checker #(.DEPTH(2), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .flush(s_flush),
    .pred_valid(s_pred_valid), .pred_target(s_pred_target), .pred_hit(s_pred_hit),
    .pred_ready(s_pred_ready), .res_valid(s_res_valid), .res_target(s_res_target),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt), .q_count(s_q_count)
  );

  typedef struct {
    int          cyc;
    logic [31:0] pc;
  } redir_t;

  redir_t      sb[$];
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_hit, exp_miss;

  task automatic expect_redirect(input logic [31:0] pc);
    sb.push_back('{cyc + 1, pc});
  endtask

  // Advance one clock and check the redirect output against the scoreboard.
  task automatic cycle();
    redir_t e;
    @(posedge clk);
    #1;
    cyc++;
    compared++;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (redirect_valid !== 1'b1 || redirect_pc !== e.pc) begin
        $display("FAIL redirect cyc=%0d: got valid=%b pc=%h, want valid=1 pc=%h",
                 cyc, redirect_valid, redirect_pc, e.pc);
        mismatched++;
      end
    end else if (redirect_valid !== 1'b0) begin
      $display("FAIL spurious_redirect cyc=%0d: got valid=%b pc=%h, want valid=0",
               cyc, redirect_valid, redirect_pc);
      mismatched++;
    end
  endtask

  task automatic idle();
    flush = 1'b0; pred_valid = 1'b0; pred_target = '0; pred_hit = 1'b0;
    res_valid = 1'b0; res_target = '0;
  endtask

  task automatic enqueue(input logic [31:0] t, input logic h);
    idle();
    pred_valid = 1'b1; pred_target = t; pred_hit = h;
    cycle();
    idle();
  endtask

  task automatic resolve(input logic [31:0] t);
    idle();
    res_valid = 1'b1; res_target = t;
    cycle();
    idle();
  endtask

  task automatic check_state(input string name, input logic [3:0] q,
                             input logic [31:0] h, input logic [31:0] m);
    compared++;
    if (q_count !== q || hit_cnt !== h || miss_cnt !== m) begin
      $display("FAIL %s: got q=%0d hit=%0d miss=%0d, want q=%0d hit=%0d miss=%0d",
               name, q_count, hit_cnt, miss_cnt, q, h, m);
      mismatched++;
    end
  endtask

  task automatic test_reset();
    idle();
    s_res_valid = 1'b0; s_res_target = '0;
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    exp_hit = 0; exp_miss = 0;
    check_state("reset_state", 4'd0, 0, 0);
    compared++;
    if (pred_ready !== 1'b1 || redirect_pc !== 32'h0 || s_miss_cnt !== 2'd0) begin
      $display("FAIL reset_outputs: got ready=%b pc=%h s_miss=%0d, want ready=1 pc=0 s_miss=0",
               pred_ready, redirect_pc, s_miss_cnt);
      mismatched++;
    end
  endtask

  task automatic test_hits();
    for (int i = 1; i <= 3; i++) enqueue(32'h8000_0000 + 32'(i) * 32'h100, 1'b1);
    check_state("hits_filled", 4'd3, exp_hit, exp_miss);
    for (int i = 1; i <= 3; i++) resolve(32'h8000_0000 + 32'(i) * 32'h100);
    exp_hit += 3;
    check_state("hits_drained", 4'd0, exp_hit, exp_miss);
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) enqueue(32'h1000 + 32'(i) * 4, 1'b1);
    check_state("full_filled", 4'd8, exp_hit, exp_miss);
    compared++;
    if (pred_ready !== 1'b0) begin
      $display("FAIL full_ready: got %b, want 0", pred_ready);
      mismatched++;
    end
    pred_valid = 1'b1; pred_target = 32'h2000; pred_hit = 1'b1;
    cycle();
    check_state("full_hold_rejected", 4'd8, exp_hit, exp_miss);
    // Resolve while full: no same-cycle bypass, so the held prediction still waits.
    res_valid = 1'b1; res_target = 32'h1000;
    cycle();
    exp_hit += 1;
    check_state("full_resolve_no_bypass", 4'd7, exp_hit, exp_miss);
    compared++;
    if (pred_ready !== 1'b1) begin
      $display("FAIL full_ready_after_hit: got %b, want 1", pred_ready);
      mismatched++;
    end
    res_valid = 1'b0;
    cycle();
    idle();
    check_state("full_ninth_accepted", 4'd8, exp_hit, exp_miss);
    // Draining in order, across the tail wrap, must hit every entry.
    for (int i = 1; i < 8; i++) resolve(32'h1000 + 32'(i) * 4);
    resolve(32'h2000);
    exp_hit += 8;
    check_state("full_drained_wrap", 4'd0, exp_hit, exp_miss);
  endtask

  task automatic test_miss();
    enqueue(32'h8000_0100, 1'b1);
    enqueue(32'h8000_0200, 1'b1);
    expect_redirect(32'h8000_0104);
    resolve(32'h8000_0104);
    exp_miss += 1;
    check_state("miss_cleared", 4'd0, exp_hit, exp_miss);
    cycle();
  endtask

  task automatic test_nohit_entry();
    enqueue(32'h0, 1'b0);
    expect_redirect(32'h0);
    resolve(32'h0);
    exp_miss += 1;
    check_state("nohit_entry_miss", 4'd0, exp_hit, exp_miss);
    cycle();
  endtask

  task automatic test_empty_resolve();
    expect_redirect(32'hBFC0_0380);
    resolve(32'hBFC0_0380);
    exp_miss += 1;
    check_state("empty_resolve_miss", 4'd0, exp_hit, exp_miss);
    cycle();
  endtask

  task automatic test_back_to_back();
    enqueue(32'h0000_00A0, 1'b1);
    pred_valid = 1'b1; pred_target = 32'h0000_00B0; pred_hit = 1'b1;
    res_valid = 1'b1; res_target = 32'h0000_00A0;
    cycle();
    exp_hit += 1;
    check_state("b2b_hit_and_enq", 4'd1, exp_hit, exp_miss);
    pred_valid = 1'b1; pred_target = 32'h0000_00C0; pred_hit = 1'b1;
    res_valid = 1'b1; res_target = 32'h0000_DEAD;
    expect_redirect(32'h0000_DEAD);
    cycle();
    idle();
    exp_miss += 1;
    check_state("b2b_miss_drops_enq", 4'd0, exp_hit, exp_miss);
    // The dropped prediction must not be there to match.
    expect_redirect(32'h0000_00C0);
    resolve(32'h0000_00C0);
    exp_miss += 1;
    check_state("b2b_dropped_entry_absent", 4'd0, exp_hit, exp_miss);
    cycle();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) enqueue(32'h3000 + 32'(i) * 4, 1'b1);
    flush = 1'b1;
    pred_valid = 1'b1; pred_target = 32'h4000; pred_hit = 1'b1;
    res_valid = 1'b1; res_target = 32'h1234;
    cycle();
    idle();
    check_state("flush_clears", 4'd0, exp_hit, exp_miss);
    cycle();
    // Queue must really be empty: even the first flushed target now misses.
    expect_redirect(32'h3000);
    resolve(32'h3000);
    exp_miss += 1;
    check_state("flush_no_survivors", 4'd0, exp_hit, exp_miss);
    cycle();
  endtask

  task automatic test_reset_mid();
    enqueue(32'h5000, 1'b1);
    res_valid = 1'b1; res_target = 32'h5555;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle();
    exp_hit = 0; exp_miss = 0;
    check_state("reset_mid_state", 4'd0, 0, 0);
    compared++;
    if (redirect_pc !== 32'h0) begin
      $display("FAIL reset_mid_pc: got %h, want 0", redirect_pc);
      mismatched++;
    end
    cycle();
  endtask

  task automatic test_saturate();
    logic [1:0] want;
    for (int i = 1; i <= 5; i++) begin
      s_res_valid = 1'b1; s_res_target = 32'(i);
      cycle();
      s_res_valid = 1'b0;
      want = (i >= 3) ? 2'd3 : 2'(i);
      compared++;
      if (s_miss_cnt !== want) begin
        $display("FAIL saturate_miss_%0d: got %0d, want %0d", i, s_miss_cnt, want);
        mismatched++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_hits();
    test_full();
    test_miss();
    test_nohit_entry();
    test_empty_resolve();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_saturate();
    compared++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      mismatched++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ras_return_checker.md
Name: ras_return_checker

Overview:
- Execute-side counterpart to the IF-stage return address stack.
- IF records every return prediction it makes into an in-order in-flight queue.
- When EX resolves a `jr $ra`, the oldest recorded prediction is compared with the actual target. A mismatch raises a registered redirect to IF and clears the queue.
- Hit/miss statistics counters are maintained for performance analysis.

Parameters:
- DEPTH, 8, in-flight prediction queue entries; power of two, ≥2.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush (exception/eret); discards all in-flight predictions
- pred_valid  in  1  IF issues a return prediction this cycle
- pred_target  in  32  predicted return target (RAS top data)
- pred_hit  in  1  RAS top entry valid when predicted
- pred_ready  out  1  queue can accept a prediction; IF stalls when low
- res_valid  in  1  EX resolved a `jr $ra` this cycle
- res_target  in  32  actual return target
- redirect_valid  out  1  one-cycle mispredict pulse
- redirect_pc  out  32  correct fetch PC, valid with redirect_valid
- hit_cnt  out  CNT_W  correct return predictions
- miss_cnt  out  CNT_W  mispredicted returns
- q_count  out  $clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (reset=1 at posedge):
  - head=tail=0, q_count=0, all entries invalid.
  - redirect_valid=0, redirect_pc=0, hit_cnt=0, miss_cnt=0.
  - pred_ready=1 in the cycle after reset deasserts.
  - Reset mid-operation discards everything, including a pending redirect.
- Queue structure:
  - Circular buffer; head/tail have log2(DEPTH) bits and wrap modulo DEPTH.
  - Full/empty are derived from q_count.
- pred_ready = (q_count != DEPTH). This is combinational from registered state and independent of res_valid, so there is no same-cycle bypass when full.
- Enqueue: pred_valid && pred_ready writes {pred_target, pred_hit} at tail, then tail++ and q_count++. pred_valid while not ready is ignored; IF must hold.
- Resolve (res_valid=1, flush=0):
  - Queue non-empty: compare the head entry.
    - Hit when entry.pred_hit && entry.target == res_target: head++, q_count--, hit_cnt++.
    - Otherwise miss: redirect_valid=1 and redirect_pc=res_target on the next edge, miss_cnt++, and the whole queue is cleared (head=tail=0, q_count=0). Younger entries are wrong-path.
  - Queue empty: treated as a miss (no prediction recorded). Same redirect, miss_cnt++.
- Latency: redirect_valid is registered. It is high exactly one cycle, the cycle after the res_valid cycle.
- Simultaneous enqueue and resolve:
  - Resolve hit: both apply; q_count unchanged.
  - Resolve miss: clear wins; the same-cycle enqueue is dropped because it is wrong-path.
- flush: highest priority after reset. Clears the queue and suppresses any same-cycle enqueue or resolve. No redirect is produced, and counters do not change. A redirect registered in the previous cycle still pulses; flush only suppresses new ones.
- Counters: saturate at all-ones and never wrap.
- Each entry compares the full 32 bits; there is no partial-tag compare.

Test Plan:
- Reset then 3 predictions (0x8000_0100, 0x8000_0200, 0x8000_0300, pred_hit=1), then 3 resolves with the same targets in order -> hit_cnt=3, miss_cnt=0, redirect_valid never high, q_count returns to 0.
- Fill the queue with 8 predictions -> pred_ready=0 and q_count=8. A 9th pred_valid held high is accepted only in the cycle after one resolve hit; tail wraps to 1.
- Queue holds {0x8000_0100, 0x8000_0200}; resolve res_target=0x8000_0104 -> next cycle redirect_valid=1 and redirect_pc=0x8000_0104 for exactly 1 cycle, q_count=0, miss_cnt=1.
- Entry with pred_hit=0 and target 0x0; resolve res_target=0x0 -> counted as a miss and redirect to 0x0.
- Resolve while empty with res_target=0xBFC0_0380 -> redirect_pc=0xBFC0_0380, miss_cnt=1.
- flush asserted together with res_valid, pred_valid and 3 queued entries -> q_count=0 next cycle, no redirect, counters unchanged. Separately, force miss_cnt to all-ones and apply another miss -> miss_cnt stays all-ones.
